// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin grant with lock, burst and hold-limit rules.
// The losing master is stalled through its own HREADY; HRDATA/HRESP are wired to both masters externally.
module ahb_master_arbiter #(
   parameter int unsigned MAX_HOLD    = 8,
   parameter bit          PARK_MASTER = 1'b0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic        M0_HMASTLOCK,
   input  logic [31:0] M0_HWDATA,
   output logic        M0_HREADY,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic        M1_HMASTLOCK,
   input  logic [31:0] M1_HWDATA,
   output logic        M1_HREADY,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   output logic        HMASTER,
   input  logic        HREADY
);

   localparam logic [1:0] TRANS_IDLE = 2'b00;
   localparam logic [1:0] TRANS_BUSY = 2'b01;
   localparam logic [1:0] TRANS_SEQ  = 2'b11;
   localparam logic [8:0] HOLD_LIMIT = 9'(MAX_HOLD);

   logic       addr_owner;
   logic       data_owner;
   logic       data_active;
   logic [7:0] hold_cnt;
   logic       last_winner;

   logic       req0;
   logic       req1;
   logic       req_owner;
   logic       req_other;
   logic       hold_hit;
   logic       switch_grant;
   logic [7:0] hold_next;

   assign req0 = (M0_HTRANS != TRANS_IDLE);
   assign req1 = (M1_HTRANS != TRANS_IDLE);

   // Address phase follows the grant immediately; write data follows the previous address phase.
   always_comb begin
      HADDR     = M0_HADDR;
      HTRANS    = M0_HTRANS;
      HWRITE    = M0_HWRITE;
      HSIZE     = M0_HSIZE;
      HMASTLOCK = M0_HMASTLOCK;
      if (addr_owner) begin
         HADDR     = M1_HADDR;
         HTRANS    = M1_HTRANS;
         HWRITE    = M1_HWRITE;
         HSIZE     = M1_HSIZE;
         HMASTLOCK = M1_HMASTLOCK;
      end
   end

   assign HWDATA  = data_owner ? M1_HWDATA : M0_HWDATA;
   assign HMASTER = addr_owner;

   // A master not on the bus in either phase is stalled only while it is actually requesting.
   always_comb begin
      M0_HREADY = 1'b1;
      M1_HREADY = 1'b1;
      if ((data_active && !data_owner) || !addr_owner)
         M0_HREADY = HREADY;
      else if (req0)
         M0_HREADY = 1'b0;
      if ((data_active && data_owner) || addr_owner)
         M1_HREADY = HREADY;
      else if (req1)
         M1_HREADY = 1'b0;
   end

   // Grant decision: lock and bursts pin the owner; otherwise the waiting master gets its turn.
   always_comb begin
      req_owner    = addr_owner ? req1 : req0;
      req_other    = addr_owner ? req0 : req1;
      hold_hit     = ({1'b0, hold_cnt} + 9'd1) >= HOLD_LIMIT;
      switch_grant = 1'b0;
      if (!HMASTLOCK && (HTRANS != TRANS_SEQ) && (HTRANS != TRANS_BUSY))
         switch_grant = req_other && (!req_owner || hold_hit || (last_winner == addr_owner));
      hold_next = hold_cnt;
      if (switch_grant)
         hold_next = 8'd0;
      else if (HTRANS[1])
         hold_next = req_other ? ((hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1) : 8'd0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_owner  <= PARK_MASTER;
         data_owner  <= 1'b0;
         data_active <= 1'b0;
         hold_cnt    <= 8'd0;
         last_winner <= PARK_MASTER;
      end else if (HREADY) begin
         data_active <= HTRANS[1];
         data_owner  <= addr_owner;
         hold_cnt    <= hold_next;
         if (switch_grant) begin
            addr_owner  <= ~addr_owner;
            last_winner <= ~addr_owner;
         end
      end
   end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Two-master AHB-Lite arbiter that shares the single AHB-Lite bus (decoder/slave-mux interconnect plus slaves) between master 0 (CPU) and master 1 (DMA/display engine).
- Multiplexes address-phase and data-phase signals onto the bus.
- Stalls the losing master by holding its HREADY low.
- Grants by round-robin with burst, lock and hold-limit rules.
- Sits between the masters and the interconnect; slaves and decoder are unchanged.

Parameters:
- MAX_HOLD, 8, max consecutive accepted NONSEQ/SEQ transfers by one master while the other requests; 1..255.
- PARK_MASTER, 0, master granted out of reset.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  asynchronous active-low reset
- M0_HADDR, M1_HADDR  input  32  master address
- M0_HTRANS, M1_HTRANS  input  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- M0_HWRITE, M1_HWRITE  input  1  master write
- M0_HSIZE, M1_HSIZE  input  3  master size
- M0_HMASTLOCK, M1_HMASTLOCK  input  1  master locked sequence
- M0_HWDATA, M1_HWDATA  input  32  master write data
- M0_HREADY, M1_HREADY  output  1  per-master ready
- HADDR  output  32  bus address
- HTRANS  output  2  bus transfer type
- HWRITE  output  1  bus write
- HSIZE  output  3  bus size
- HMASTLOCK  output  1  bus lock
- HWDATA  output  32  bus write data
- HMASTER  output  1  current address-phase owner
- HREADY  input  1  bus ready from interconnect
- HRDATA, HRESP  input  32/1  passed unchanged to both masters (external wiring, not ports here)

Behaviour:
- State: addr_owner (1b), data_owner (1b), data_active (1b), hold_cnt (8b), last_winner (1b).
- Reset: addr_owner = PARK_MASTER, data_active = 0, data_owner = 0, hold_cnt = 0, last_winner = PARK_MASTER.
  - Resulting outputs: HMASTER = PARK_MASTER; bus signals mirror the PARK_MASTER inputs; HWDATA = M0_HWDATA.
- req[m] = (Mm_HTRANS != IDLE).
- Address mux is combinational from addr_owner: HADDR/HTRANS/HWRITE/HSIZE/HMASTLOCK = Mm_* for m = addr_owner.
- HWDATA = Mm_HWDATA for m = data_owner.
- Per-master ready, combinational:
  - Mm_HREADY = HREADY if (data_active && data_owner == m) || addr_owner == m.
  - else 0 if req[m] (stalled; AHB-Lite master holds its address).
  - else 1.
- Register updates occur only on HCLK edges with HREADY = 1. All state holds while HREADY = 0.
  - data_active <= (HTRANS[1] == 1); data_owner <= addr_owner.
  - Accepted transfer (HTRANS NONSEQ/SEQ): hold_cnt <= hold_cnt + 1 if req[other] else 0; saturates at 255.
- Next grant, evaluated at each HREADY = 1 edge, first match wins:
  1. Owner HMASTLOCK = 1 -> keep.
  2. Owner HTRANS = SEQ or BUSY -> keep (never split a burst); the hold limit is deferred to the next NONSEQ/IDLE.
  3. req[other] && (!req[owner] || hold_cnt + 1 >= MAX_HOLD || last_winner == owner) -> switch to other.
  4. Else keep (includes both idle: bus parks on last owner).
  - On switch: hold_cnt <= 0, last_winner <= new owner.
- Switch latency: the stalled master's address appears on the bus the cycle after the switching edge. Its HREADY rises together with the previous owner's data-phase completion.
- Simultaneous first requests from reset: master != last_winner wins (PARK_MASTER's peer). If PARK_MASTER itself requests alone, no switch.
- HRESP ERROR: no special arbitration; the grant rule still applies at HREADY = 1 edges.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous); no transfer completion is guaranteed.

Test Plan:
- Reset, PARK_MASTER = 0, both idle -> HMASTER = 0, M0_HREADY = M1_HREADY = 1, HADDR = M0_HADDR.
- M1 single NONSEQ write to 0x2000_0004 with data 0xA5A5_0001, M0 idle -> HMASTER = 1 after one edge; HWDATA = 0xA5A5_0001 in the data phase; M1_HREADY follows HREADY.
- Both continuously issue NONSEQ, MAX_HOLD = 8 -> ownership alternates each transfer (round-robin); loser's HREADY = 0 and its HADDR held stable.
- M0 INCR4 burst (NONSEQ + 3 SEQ) while M1 requests -> no switch until the burst ends; M1 granted at the edge after the last SEQ is accepted.
- M0 HMASTLOCK = 1 for 12 transfers, M1 requesting -> M1_HREADY = 0 throughout; switch at the first edge after lock deasserts; slave inserts 2 wait states on the final M0 transfer -> no grant change until HREADY = 1.
- HRESETn pulsed low during an M1 data phase -> HMASTER = 0 and data_active cleared asynchronously; M1 retries NONSEQ and is granted.
